// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch sequencer in front of the processor.
// Owns the program counter, reads a synchronous-read program ROM, issues each
// instruction with a one-cycle Run strobe and waits for Done before advancing.
// For move-immediate instructions the following ROM word is prefetched and
// presented on DIN from the cycle after Run until Done.
//
// Optional feature: define IFETCH_WDOG_EN to add a WAIT-state watchdog and the
// sticky Err output.
//
// Ports:
//   Clock    in   single clock, rising edge
//   Resetn   in   asynchronous active-low reset
//   Start    in   level enable for fetch/issue
//   Done     in   processor completion pulse (only observed in WAIT)
//   MemData  in   ROM read data, valid one cycle after MemAddr
//   MemAddr  out  ROM read address (combinational)
//   DIN      out  word presented to the processor
//   Run      out  one-cycle issue strobe
//   Busy     out  high in every state except IDLE
//   PC       out  address of the next instruction to fetch
//   Err      out  sticky watchdog flag (IFETCH_WDOG_EN only)
module instr_fetch #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DATA_W   = 16,
   parameter logic [2:0]  MVI_OPC  = 3'b001,
   parameter int unsigned WDOG_CYC = 15
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Start,
   input  logic              Done,
   input  logic [DATA_W-1:0] MemData,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] DIN,
   output logic              Run,
   output logic              Busy,
   output logic [ADDR_W-1:0] PC
`ifdef IFETCH_WDOG_EN
   ,
   output logic              Err
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_I,
      S_LAT_I,
      S_LAT_D,
      S_ISSUE,
      S_WAIT
   } state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] pc, pc_n, pc_step, addr_c;
   logic [DATA_W-1:0] ir_q, ir_n, imm_q, imm_n, din_q, din_n;
   logic              is_mvi, is_mvi_n;
   logic              run_q, run_n, busy_q, busy_n;

`ifdef IFETCH_WDOG_EN
   localparam int unsigned WDOG_W = $clog2(WDOG_CYC + 1);
   logic [WDOG_W-1:0] wdog_q, wdog_n;
   logic              err_q, err_n;
`else
   // Watchdog limit has no effect without the watchdog.
   logic unused_wdog_cfg;
   assign unused_wdog_cfg = ^32'(WDOG_CYC);
`endif

   // mvi consumes two ROM words
   assign pc_step = is_mvi ? ADDR_W'(2) : ADDR_W'(1);

   // State and datapath registers
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state  <= S_IDLE;
         pc     <= '0;
         ir_q   <= '0;
         imm_q  <= '0;
         is_mvi <= 1'b0;
         din_q  <= '0;
         run_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state  <= state_n;
         pc     <= pc_n;
         ir_q   <= ir_n;
         imm_q  <= imm_n;
         is_mvi <= is_mvi_n;
         din_q  <= din_n;
         run_q  <= run_n;
         busy_q <= busy_n;
      end
   end

`ifdef IFETCH_WDOG_EN
   // Watchdog counter and sticky error flag
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wdog_q <= wdog_n;
         err_q  <= err_n;
      end
   end
`endif

   // Next-state, datapath and ROM address
   always_comb begin
      state_n  = state;
      pc_n     = pc;
      ir_n     = ir_q;
      imm_n    = imm_q;
      is_mvi_n = is_mvi;
      din_n    = din_q;
      addr_c   = pc;
`ifdef IFETCH_WDOG_EN
      wdog_n   = wdog_q;
      err_n    = err_q;
`endif

      unique case (state)
         S_IDLE: begin
            if (Start) state_n = S_RD_I;
         end
         S_RD_I: begin
            state_n = S_LAT_I;
         end
         S_LAT_I: begin
            ir_n     = MemData;
            is_mvi_n = (MemData[8:6] == MVI_OPC);
            if (is_mvi_n) begin
               // Present the immediate address now so it lands in LAT_D
               addr_c  = pc + ADDR_W'(1);
               state_n = S_LAT_D;
            end else begin
               state_n = S_ISSUE;
            end
         end
         S_LAT_D: begin
            imm_n   = MemData;
            addr_c  = pc + ADDR_W'(1);
            state_n = S_ISSUE;
         end
         S_ISSUE: begin
            state_n = S_WAIT;
`ifdef IFETCH_WDOG_EN
            wdog_n  = '0;
`endif
         end
         S_WAIT: begin
            if (Done) begin
               pc_n    = pc + pc_step;
               addr_c  = pc_n;
               state_n = Start ? S_RD_I : S_IDLE;
            end
`ifdef IFETCH_WDOG_EN
            else if (wdog_q == WDOG_W'(WDOG_CYC - 1)) begin
               // Give up on this instruction and skip past it
               pc_n    = pc + pc_step;
               err_n   = 1'b1;
               state_n = S_IDLE;
            end else begin
               wdog_n  = wdog_q + WDOG_W'(1);
            end
`endif
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      // Registered outputs follow the state being entered
      run_n  = (state_n == S_ISSUE);
      busy_n = (state_n != S_IDLE);
      if (state_n == S_ISSUE) begin
         din_n = ir_n;
      end else if (state_n == S_WAIT) begin
         din_n = is_mvi_n ? imm_n : ir_n;
      end
   end

   assign MemAddr = addr_c;
   assign DIN     = din_q;
   assign Run     = run_q;
   assign Busy    = busy_q;
   assign PC      = pc;
`ifdef IFETCH_WDOG_EN
   assign Err     = err_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios with literal expectations plus
// randomized Start/Done/ROM traffic checked every cycle against a
// transaction-level model (position within the current instruction).
module tb_instr_fetch;

   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned WDOG_CYC = 15;
   localparam int unsigned DEPTH    = 1 << ADDR_W;

   logic              Clock  = 1'b0;
   logic              Resetn = 1'b1;
   logic              Start  = 1'b0;
   logic              Done   = 1'b0;
   logic [DATA_W-1:0] MemData;
   logic [ADDR_W-1:0] MemAddr;
   logic [DATA_W-1:0] DIN;
   logic              Run;
   logic              Busy;
   logic [ADDR_W-1:0] PC;
`ifdef IFETCH_WDOG_EN
   logic              Err;
`endif

   logic [DATA_W-1:0] rom [DEPTH];

   int checks = 0;
   int passes = 0;

   instr_fetch #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .MVI_OPC (3'b001),
      .WDOG_CYC(WDOG_CYC)
   ) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .Start  (Start),
      .Done   (Done),
      .MemData(MemData),
      .MemAddr(MemAddr),
      .DIN    (DIN),
      .Run    (Run),
      .Busy   (Busy),
      .PC     (PC)
`ifdef IFETCH_WDOG_EN
      ,
      .Err    (Err)
`endif
   );

   always #5 Clock = ~Clock;

   // Synchronous-read program ROM
   always @(posedge Clock) MemData <= rom[MemAddr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp)
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      else
         passes++;
   endtask

   function automatic bit word_is_mvi(input logic [DATA_W-1:0] w);
      return (w[8:6] == 3'b001);
   endfunction

   // ---------------- reference model ----------------
   // m_t counts cycles since the fetch began: 0 reads, 1 latches, the
   // instruction issues at 2 (3 for mvi), and anything later is waiting.
   logic [ADDR_W-1:0] mpc;
   bit                m_act;
   int                m_t;
   logic [DATA_W-1:0] mdin;
   bit                m_err;

   always @(posedge Clock or negedge Resetn) begin : model
      logic [DATA_W-1:0] w;
      bit mv;
      int iss;
      if (!Resetn) begin
         mpc   = '0;
         m_act = 1'b0;
         m_t   = 0;
         mdin  = '0;
         m_err = 1'b0;
      end else begin
         w   = rom[mpc];
         mv  = word_is_mvi(w);
         iss = mv ? 3 : 2;
         if (!m_act) begin
            if (Start) begin
               m_act = 1'b1;
               m_t   = 0;
            end
         end else if (m_t <= iss) begin
            m_t++;
         end else if (Done) begin
            mpc = mpc + ADDR_W'(mv ? 2 : 1);
            if (Start) m_t = 0;
            else       m_act = 1'b0;
         end
`ifdef IFETCH_WDOG_EN
         else if (m_t - iss == int'(WDOG_CYC)) begin
            mpc   = mpc + ADDR_W'(mv ? 2 : 1);
            m_act = 1'b0;
            m_err = 1'b1;
         end
`endif
         else begin
            m_t++;
         end
         // DIN expectation for the position just entered
         w   = rom[mpc];
         mv  = word_is_mvi(w);
         iss = mv ? 3 : 2;
         if (m_act && m_t >= iss)
            mdin = (m_t == iss || !mv) ? w : rom[mpc + ADDR_W'(1)];
      end
   end

   // Per-cycle comparison against the model
   always @(negedge Clock) begin : compare
      logic [DATA_W-1:0] w;
      bit mv;
      int iss;
      logic [ADDR_W-1:0] eaddr;
      w   = rom[mpc];
      mv  = word_is_mvi(w);
      iss = mv ? 3 : 2;
      eaddr = mpc;
      if (m_act && mv && (m_t == 1 || m_t == 2)) eaddr = mpc + ADDR_W'(1);
      if (m_act && m_t > iss && Done)            eaddr = mpc + ADDR_W'(mv ? 2 : 1);
      check("model_run",  32'(Run),     32'(m_act && m_t == iss));
      check("model_busy", 32'(Busy),    32'(m_act));
      check("model_pc",   32'(PC),      32'(mpc));
      check("model_addr", 32'(MemAddr), 32'(eaddr));
      check("model_din",  32'(DIN),     32'(mdin));
`ifdef IFETCH_WDOG_EN
      check("model_err",  32'(Err),     32'(m_err));
`endif
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic wait_run(input int lim);
      bit seen = 1'b0;
      for (int i = 0; i < lim; i++) begin
         tick();
         if (Run) begin
            seen = 1'b1;
            break;
         end
      end
      check("run_seen", 32'(seen), 32'd1);
   endtask

   task automatic wait_idle(input int lim);
      bit seen = 1'b0;
      for (int i = 0; i < lim; i++) begin
         tick();
         if (!Busy) begin
            seen = 1'b1;
            break;
         end
      end
      check("idle_seen", 32'(seen), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         rom[i] = DATA_W'($urandom);
         if (word_is_mvi(rom[i])) rom[i][6] = 1'b0;
      end
      rom[0]  = 16'h0008;
      rom[1]  = 16'h0040;
      rom[2]  = 16'h1234;
      rom[31] = 16'h0040;

      // Reset with Start low
      #1 Resetn = 1'b0;
      repeat (3) @(posedge Clock);
      #1 Resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_run", 32'(Run), 32'd0);
      end
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_pc",   32'(PC), 32'd0);
      check("rst_addr", 32'(MemAddr), 32'd0);
      check("rst_din",  32'(DIN), 32'd0);

      // Single non-mvi instruction
      Start = 1'b1;
      tick();
      tick();
      check("nm_lat_run", 32'(Run), 32'd0);
      tick();
      check("nm_run", 32'(Run), 32'd1);
      check("nm_din", 32'(DIN), 32'h0008);
      Start = 1'b0;
      tick();
      check("nm_wait_run", 32'(Run), 32'd0);
      Done = 1'b1;
      tick();
      Done = 1'b0;
      check("nm_pc",   32'(PC), 32'd1);
      check("nm_addr", 32'(MemAddr), 32'd1);
      check("nm_busy", 32'(Busy), 32'd0);

      // mvi at address 1 with its immediate at address 2
      Start = 1'b1;
      tick();
      tick();
      tick();
      check("mvi_latd_run", 32'(Run), 32'd0);
      tick();
      check("mvi_run", 32'(Run), 32'd1);
      check("mvi_din", 32'(DIN), 32'h0040);
      Start = 1'b0;
      tick();
      check("mvi_imm0", 32'(DIN), 32'h1234);
      tick();
      check("mvi_imm1", 32'(DIN), 32'h1234);
      Done = 1'b1;
      tick();
      Done = 1'b0;
      check("mvi_pc", 32'(PC), 32'd3);

      // Run back-to-back up to the mvi at the last address
      rom[0] = 16'hBEEF;
      Start = 1'b1;
      Done  = 1'b1;
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 300; i++) begin
            tick();
            if (Run && PC == ADDR_W'(31)) begin
               seen = 1'b1;
               break;
            end
         end
         check("wrap_reach", 32'(seen), 32'd1);
      end
      check("wrap_din_ir", 32'(DIN), 32'h0040);
      Done  = 1'b0;
      Start = 1'b0;
      tick();
      check("wrap_imm", 32'(DIN), 32'hBEEF);
      Done = 1'b1;
      tick();
      Done = 1'b0;
      check("wrap_pc",   32'(PC), 32'd1);
      check("wrap_busy", 32'(Busy), 32'd0);

      // Asynchronous reset in the middle of WAIT
      Start = 1'b1;
      wait_run(10);
      Start = 1'b0;
      tick();
      check("ar_busy_pre", 32'(Busy), 32'd1);
      #1 Resetn = 1'b0;
      #1;
      check("ar_run",  32'(Run), 32'd0);
      check("ar_busy", 32'(Busy), 32'd0);
      check("ar_pc",   32'(PC), 32'd0);
      check("ar_din",  32'(DIN), 32'd0);
      @(posedge Clock);
      #1 Resetn = 1'b1;

`ifdef IFETCH_WDOG_EN
      // Watchdog: Done never arrives for the instruction at 0
      Start = 1'b1;
      wait_run(10);
      for (int i = 0; i < int'(WDOG_CYC); i++) tick();
      check("wd_err_early", 32'(Err), 32'd0);
      tick();
      check("wd_err",  32'(Err), 32'd1);
      check("wd_busy", 32'(Busy), 32'd0);
      check("wd_pc",   32'(PC), 32'd1);
      Done = 1'b1;
      repeat (12) tick();
      check("wd_sticky", 32'(Err), 32'd1);
      Done  = 1'b0;
      Start = 1'b0;
`endif

      // Randomized traffic over a fresh ROM with plenty of mvi words
      Start = 1'b0;
      Done  = 1'b1;
      wait_idle(40);
      Done  = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         rom[i] = DATA_W'($urandom);
         if ($urandom_range(0, 99) < 35) rom[i][8:6] = 3'b001;
      end
      for (int c = 0; c < 3000; c++) begin
         Start = ($urandom_range(0, 9) < 8);
         Done  = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 399) == 0) begin
            #1 Resetn = 1'b0;
            #2 Resetn = 1'b1;
         end
         tick();
      end
      Start = 1'b0;
      Done  = 1'b1;
      wait_idle(40);
      Done  = 1'b0;
      repeat (3) tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer directly upstream of the processor. It owns the program counter, reads instruction words from a synchronous-read program ROM, and drives the processor's `DIN` and `Run` inputs. It waits for the processor's `Done` before advancing. For move-immediate instructions it pre-fetches the following data word and presents it on `DIN` during the processor's second time step.

## Interface
- `ADDR_W`, default 5: ROM address width; PC width.
- `DATA_W`, default 16: ROM/instruction word width, ≥ 9.
- `MVI_OPC`, default 3'b001: opcode value, in `DIN[8:6]`, that carries an immediate word.
- `WDOG_CYC`, default 15: watchdog limit in cycles (used only with `IFETCH_WDOG_EN`).
- `Clock`  in  1  single clock; all state updates on rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `Start`  in  1  level enable: fetch/issue continues while high.
- `Done`  in  1  processor completion pulse.
- `MemData`  in  DATA_W  ROM read data, valid one cycle after `MemAddr`.
- `MemAddr`  out  ADDR_W  ROM read address.
- `DIN`  out  DATA_W  word presented to the processor.
- `Run`  out  1  one-cycle issue strobe to the processor.
- `Busy`  out  1  high in every state except IDLE.
- `PC`  out  ADDR_W  address of the next instruction to fetch.
- `Err`  out  1  sticky watchdog flag; exists only with `IFETCH_WDOG_EN`.

## Operation
- **Registers:** `pc`, `ir_q` (instruction), `imm_q` (data word), `is_mvi`, state.
- **IDLE:** `MemAddr=pc`. If `Start=1`, go to RD_I.
- **RD_I:** ROM is reading `pc`. Go to LAT_I.
- **LAT_I:** `ir_q<=MemData`; `is_mvi <= (MemData[8:6]==MVI_OPC)`.
  - If mvi: `MemAddr=pc+1` (modulo 2^ADDR_W), go to LAT_D.
  - Otherwise go to ISSUE.
- **LAT_D:** `imm_q<=MemData`. Go to ISSUE.
- **ISSUE:** `Run=1`, `DIN=ir_q`. Go to WAIT.
- **WAIT:** `DIN = is_mvi ? imm_q : ir_q`; `Run=0`.
  - When `Done=1`: `pc <= pc + (is_mvi ? 2 : 1)`, modulo 2^ADDR_W.
  - Then if `Start=1` go to RD_I with `MemAddr` = the new pc (combinational from next-pc); otherwise go to IDLE.
- **Outside LAT_D and the WAIT-exit cycle:** `MemAddr=pc`.
- **`DIN` in IDLE/RD_I/LAT_I/LAT_D:** holds its last value.
- **Done handling:** `Done` outside WAIT is ignored.
- **Start handling:** `Start` falling mid-instruction does not abort; the sequencer finishes through `Done`, then returns to IDLE.
- **PC wrap:** PC wraps at 2^ADDR_W−1 → 0. An mvi at the last address takes its data word from address 0, and the next pc is 1.
- **Reset values (asynchronous, immediate):** state=IDLE, `pc=0`, `ir_q=0`, `imm_q=0`, `DIN=0`, `Run=0`, `Busy=0`, `MemAddr=0`, `Err=0`. A reset mid-instruction discards it; no `Run` is issued after reset until `Start`.

## Timing
- **Non-mvi issue latency:** `Start` sampled high at edge n → `Run` high in cycle n+3 (RD_I, LAT_I, ISSUE).
- **mvi issue latency:** `Run` high in cycle n+4.
- **Run width:** exactly one cycle per instruction.
- **Immediate timing:** for mvi, `DIN=imm_q` from the cycle after `Run` (processor T1) until `Done`.
- **Back-to-back:** `Done` sampled at edge m with `Start=1` → RD_I in cycle m+1. The next `Run` is at m+3 (non-mvi).
- **Minimum rate:** one non-mvi instruction per 4 cycles, assuming a 1-cycle `Done`.

## Configuration
- **Macro:** `IFETCH_WDOG_EN`.
- **Defined:**
  - A counter runs in WAIT and clears on entry to WAIT.
  - If `Done` is not seen within WDOG_CYC cycles of WAIT, `Err` goes high (sticky until reset) and the state goes to IDLE.
  - `pc` advances by 1 (mvi: by 2) as if the instruction completed.
- **Undefined:**
  - No counter and no `Err` port; WAIT waits indefinitely.

## Test plan
- **Reset:** `Resetn` low, then high, with `Start=0` → all outputs 0; state stays IDLE; `Run` never asserts.
- **Single non-mvi:** ROM[0]=16'h0008 (mv R0,R1), `Start=1` at edge 0 → `Run` in cycle 3 with `DIN=16'h0008`; after `Done`, `PC=1`, `MemAddr=1`.
- **mvi:** ROM[0]=16'h0040, ROM[1]=16'h1234 → `Run` in cycle 4 with `DIN=16'h0040`; `DIN=16'h1234` from cycle 5 until `Done`; `PC=2`.
- **Wrap:** ADDR_W=5, pc=31, ROM[31]=16'h0040, ROM[0]=16'hBEEF → immediate=16'hBEEF; next `PC=1`.
- **Stop and reset mid-operation:** `Start` dropped in ISSUE → `Done` still awaited, then IDLE with pc advanced. Separately, `Resetn` pulsed low in WAIT → `Run`/`Busy`/`PC` = 0 immediately, asynchronously.
- **Watchdog (`IFETCH_WDOG_EN`):** `Done` held low → `Err=1` after 15 WAIT cycles, state IDLE, `PC=1`; `Err` stays 1 across further instructions until reset.
